// File: rtl/s4ga_cfg_tx.sv
// Configuration transmitter for an S4GA LUT fabric: holds one frame per target LUT
// and streams every frame, MSB segment first, after holding the target in reset.
//
// state  | meaning
// IDLE   | target held in reset, waiting for run
// RESET  | target held in reset for N+1 cycles before streaming
// STREAM | frames shifted out back to back, LUT 0 .. N-1
module s4ga_cfg_tx #(
   parameter int N    = 101,
   parameter int K    = 5,
   parameter int SI_W = 4,
   localparam int N_W        = $clog2(N),
   localparam int MASK_W     = 2**K,
   localparam int IDX_SEGS   = (N_W + SI_W - 1) / SI_W,
   localparam int MASK_SEGS  = (MASK_W + SI_W - 1) / SI_W,
   localparam int FRAME_SEGS = K*IDX_SEGS + MASK_SEGS,
   localparam int FRAME_W    = FRAME_SEGS*SI_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               cfg_we,
   input  logic [N_W-1:0]     cfg_addr,
   input  logic [FRAME_W-1:0] cfg_wdata,
   output logic [SI_W-1:0]    si,
   output logic               tgt_rst,
   output logic               busy,
   output logic [N_W-1:0]     lut_idx,
   output logic               sweep_done
);

   localparam int SEG_W = (FRAME_SEGS > 1) ? $clog2(FRAME_SEGS) : 1;
   localparam int RC_W  = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RESET, STREAM} state_t;

   state_t             state;
   logic [FRAME_W-1:0] mem [N];
   logic [FRAME_W-1:0] sreg;
   logic [SEG_W-1:0]   seg;
   logic [RC_W-1:0]    rcnt;

   logic               last_seg;
   logic               last_lut;
   logic [SEG_W-1:0]   nxt_seg;
   logic [N_W-1:0]     nxt_idx;

   // Memory has no reset so stored frames survive an aborted sweep.
   always_ff @(posedge clk) begin
      if (cfg_we && (int'(cfg_addr) < N))
         mem[cfg_addr] <= cfg_wdata;
   end

   always_comb begin
      last_seg = (seg == SEG_W'(FRAME_SEGS - 1));
      last_lut = (lut_idx == N_W'(N - 1));
      nxt_seg  = last_seg ? '0 : seg + 1'b1;
      nxt_idx  = lut_idx;
      if (last_seg)
         nxt_idx = last_lut ? '0 : lut_idx + 1'b1;
   end

   // si is taken straight from the shift register, which is cleared outside STREAM.
   assign si = sreg[FRAME_W-1 -: SI_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sreg       <= '0;
         tgt_rst    <= 1'b1;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
         lut_idx    <= '0;
         seg        <= '0;
         rcnt       <= '0;
      end else begin
         sweep_done <= 1'b0;
         case (state)
            IDLE: begin
               if (run) begin
                  state <= RESET;
                  busy  <= 1'b1;
                  rcnt  <= RC_W'(N);
               end
            end
            RESET: begin
               if (rcnt == '0) begin
                  state   <= STREAM;
                  tgt_rst <= 1'b0;
                  seg     <= '0;
                  lut_idx <= '0;
                  sreg    <= mem[lut_idx];
               end else begin
                  rcnt <= rcnt - 1'b1;
               end
            end
            STREAM: begin
               seg        <= nxt_seg;
               lut_idx    <= nxt_idx;
               sweep_done <= (nxt_seg == SEG_W'(FRAME_SEGS - 1)) && (nxt_idx == N_W'(N - 1));
               if (last_seg && last_lut && !run) begin
                  state      <= IDLE;
                  tgt_rst    <= 1'b1;
                  busy       <= 1'b0;
                  sreg       <= '0;
                  sweep_done <= 1'b0;
               end else if (last_seg) begin
                  // Read happens on the same edge as any write, so the old frame is taken.
                  sreg <= mem[nxt_idx];
               end else begin
                  sreg <= sreg << SI_W;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/s4ga_cfg_tx.md
S4GA_CFG_TX -- requirements
Module: s4ga_cfg_tx

Interface
REQ-001 Parameter N, default 101: number of target LUTs; must equal the target fabric's N.
REQ-002 Parameter K, default 5: number of inputs per target LUT.
REQ-003 Parameter SI_W, default 4: segment width in bits per clock.
REQ-004 Derived: N_W=clog2(N); MASK_W=2**K; IDX_SEGS=ceil(N_W/SI_W); MASK_SEGS=ceil(MASK_W/SI_W); FRAME_SEGS=K*IDX_SEGS+MASK_SEGS; FRAME_W=FRAME_SEGS*SI_W.
REQ-005 Port clk, input, 1: single clock, shared with the target fabric.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port run, input, 1: level request to stream configuration sweeps.
REQ-008 Port cfg_we, input, 1: configuration-memory write strobe.
REQ-009 Port cfg_addr, input, N_W: index of the LUT to write.
REQ-010 Port cfg_wdata, input, FRAME_W: frame {idx0,...,idx(K-1),mask}; idx0 in the MSBs; each idx field is IDX_SEGS*SI_W bits, value zero-extended; the mask field is MASK_SEGS*SI_W bits.
REQ-011 Port si, output, SI_W: segment stream to the target.
REQ-012 Port tgt_rst, output, 1: active-high synchronous reset to the target.
REQ-013 Port busy, output, 1: high in RESET and STREAM.
REQ-014 Port lut_idx, output, N_W: index of the LUT whose frame is on si.
REQ-015 Port sweep_done, output, 1: one-cycle pulse.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The block SHALL hold N frames of FRAME_W bits; cfg_we with cfg_addr<N SHALL write cfg_wdata to entry cfg_addr on that clock edge; cfg_addr>=N SHALL be ignored; writes SHALL be accepted in every state.
REQ-018 FSM states SHALL be IDLE, RESET and STREAM.
REQ-019 IDLE: tgt_rst=1, si=0, busy=0; run sampled 1 SHALL transition to RESET.
REQ-020 RESET: tgt_rst=1, si=0; the block SHALL remain in RESET exactly N+1 cycles, then transition to STREAM with lut_idx=0; run is ignored in RESET.
REQ-021 STREAM: tgt_rst=0; each LUT SHALL occupy FRAME_SEGS consecutive cycles; si SHALL be the top SI_W bits of a frame shift register that shifts left by SI_W each cycle (frame MSB-first); there SHALL be no gap cycles between frames.
REQ-022 The frame SHALL be copied from the memory entry at lut_idx on the first segment cycle of each frame; a write to that entry on the same edge SHALL NOT affect the copied frame; it takes effect at the next sweep.
REQ-023 lut_idx SHALL increment after each frame's last segment and wrap from N-1 to 0.
REQ-024 sweep_done SHALL be 1 exactly during the last segment cycle of LUT N-1.
REQ-025 If run is 0 when sampled in a sweep's last segment cycle, the next state SHALL be IDLE; otherwise the next sweep starts with no gap; a run deassertion earlier in the sweep SHALL NOT truncate the sweep.
REQ-026 The segment counter SHALL be wide enough for FRAME_SEGS-1 and SHALL wrap to 0 at each frame boundary.

Reset
REQ-027 While rst_n=0: state=IDLE, si=0, tgt_rst=1, busy=0, sweep_done=0, lut_idx=0, counters=0.
REQ-028 rst_n asserted mid-sweep SHALL abort the sweep immediately (asynchronously); memory contents SHALL be preserved.
REQ-029 Memory SHALL NOT be reset; its contents are undefined until written.

Verification (N=5, K=2, SI_W=4 => FRAME_SEGS=3, FRAME_W=12)
REQ-030 Write LUT0..4 = 12'h12A,12'h34B,12'h00C,12'h41D,12'h23E; pulse run for one cycle in IDLE -> tgt_rst=1 for 6 cycles after the RESET entry; then si = 1,2,A,3,4,B,0,0,C,4,1,D,2,3,E; sweep_done high on the E cycle; then IDLE with tgt_rst=1.
REQ-031 run held 1 -> a second sweep begins directly after E with si=1; lut_idx follows 0,0,0,1,1,1,...,4,4,4,0.
REQ-032 Write LUT0=12'hFFF on LUT0's first segment cycle -> the current sweep sends 1,2,A; the next sweep sends F,F,F.
REQ-033 cfg_we with cfg_addr=6 -> memory unchanged; the stream is identical to REQ-030.
REQ-034 rst_n low during LUT2's second segment -> outputs take their reset values immediately; run high again -> full RESET period, then the stream restarts at LUT0 with the stored data.
REQ-035 run dropped during LUT1 -> the sweep completes through LUT4, then IDLE; busy falls the cycle after sweep_done.
